// File: rtl/sram2rw_fifo_ctrl.sv
// FIFO controller around a 64x8 two-port SRAM: port 1 writes, port 2 reads, and a 2-entry skid
// buffer hides the registered read latency. Define SRAM2RW_FIFO_BYPASS_EN to route enqueues into an empty FIFO straight to the output buffer.
module sram2rw_fifo_ctrl #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 3)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_bits,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic [CW-1:0]    count,
    output logic [AW-1:0]    sram_a1,
    output logic [WIDTH-1:0] sram_i1,
    output logic             sram_csb1,
    output logic             sram_web1,
    output logic             sram_oeb1,
    output logic [AW-1:0]    sram_a2,
    output logic             sram_csb2,
    output logic             sram_web2,
    output logic             sram_oeb2,
    input  logic [WIDTH-1:0] sram_o2
);

    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);

    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_sram_cnt;
    logic             r_inflight;
    logic [1:0]       r_ob_cnt;
    logic [WIDTH-1:0] r_ob_head;
    logic [WIDTH-1:0] r_ob_tail;

    logic             w_enq_fire;
    logic             w_byp;
    logic             w_wr;
    logic             w_rd;
    logic             w_deq_fire;
    logic             w_push;
    logic [WIDTH-1:0] w_push_data;
    logic [2:0]       w_ob_pend;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // ready never depends on the same side's valid, and valid is held until it is taken.
    assign enq_ready  = !reset && (r_sram_cnt < LP_DEPTH);
    assign w_enq_fire = enq_valid && enq_ready;
    assign deq_valid  = (r_ob_cnt != 2'd0);
    assign w_deq_fire = deq_valid && deq_ready;
    assign deq_bits   = r_ob_head;

`ifdef SRAM2RW_FIFO_BYPASS_EN
    assign w_byp = (r_sram_cnt == '0) && !r_inflight && (r_ob_cnt != 2'd2);
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr = w_enq_fire && !w_byp;

    // Slots the output buffer will need once the current dequeue and in-flight read settle.
    assign w_ob_pend = 3'(r_ob_cnt) + 3'(r_inflight) - 3'(w_deq_fire);
    assign w_rd      = !reset && (r_sram_cnt != '0) && (w_ob_pend < 3'd2);

    // Bypass only fires with nothing in flight, so the two push sources never collide.
    assign w_push      = r_inflight || (w_enq_fire && w_byp);
    assign w_push_data = r_inflight ? sram_o2 : enq_bits;

    assign sram_csb1 = !w_wr;
    assign sram_web1 = !w_wr;
    assign sram_oeb1 = 1'b1;
    assign sram_a1   = w_wr ? r_wptr : '0;
    assign sram_i1   = w_wr ? enq_bits : '0;

    assign sram_csb2 = !w_rd;
    assign sram_web2 = 1'b1;
    assign sram_oeb2 = !w_rd;
    assign sram_a2   = w_rd ? r_rptr : '0;

    assign count = CW'(r_sram_cnt) + CW'(r_inflight) + CW'(r_ob_cnt);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_sram_cnt <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_sram_cnt <= r_sram_cnt + (AW + 1)'(1);
                2'b01:   r_sram_cnt <= r_sram_cnt - (AW + 1)'(1);
                default: r_sram_cnt <= r_sram_cnt;
            endcase
            r_inflight <= w_rd;
        end
    end

    // Two-entry output buffer: head drives deq_bits, tail holds the younger word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ob_cnt  <= 2'd0;
            r_ob_head <= '0;
            r_ob_tail <= '0;
        end else begin
            case ({w_push, w_deq_fire})
                2'b10: begin
                    if (r_ob_cnt == 2'd0) begin
                        r_ob_head <= w_push_data;
                    end else begin
                        r_ob_tail <= w_push_data;
                    end
                    r_ob_cnt <= r_ob_cnt + 2'd1;
                end
                2'b01: begin
                    r_ob_head <= r_ob_tail;
                    r_ob_cnt  <= r_ob_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_ob_cnt == 2'd1) begin
                        r_ob_head <= w_push_data;
                    end else begin
                        r_ob_head <= r_ob_tail;
                        r_ob_tail <= w_push_data;
                    end
                end
                default: begin
                    r_ob_cnt <= r_ob_cnt;
                end
            endcase
        end
    end

    a_no_same_addr: assert property (@(posedge clock) disable iff (reset)
        !(w_wr && w_rd && (sram_a1 == sram_a2)));

    a_ptr_meet: assert property (@(posedge clock) disable iff (reset)
        (r_wptr == r_rptr) |-> ((r_sram_cnt == '0) || (r_sram_cnt == LP_DEPTH)));

    a_ob_bound: assert property (@(posedge clock) disable iff (reset)
        (3'(r_ob_cnt) + 3'(r_inflight)) <= 3'd2);

    a_count_max: assert property (@(posedge clock) disable iff (reset)
        count <= CW'(DEPTH + 2));

    a_sram_bound: assert property (@(posedge clock) disable iff (reset)
        r_sram_cnt <= LP_DEPTH);

    a_reset_idle: assert property (@(posedge clock)
        reset |-> (sram_csb1 && sram_csb2 && !enq_ready));

endmodule

// File: tb/tb_sram2rw_fifo_ctrl.sv
// Bench for sram2rw_fifo_ctrl: a behavioural SRAM, a queue reference model fed by the driver,
// and a monitor that pops and compares on every dequeue handshake.
module tb_sram2rw_fifo_ctrl;

    localparam int DEPTH = 64;
    localparam int WIDTH = 8;
    localparam int AW    = 6;
    localparam int CW    = 7;
`ifdef SRAM2RW_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic             clock;
    logic             reset;
    logic             enq_valid;
    logic             enq_ready;
    logic [WIDTH-1:0] enq_bits;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic [CW-1:0]    count;
    logic [AW-1:0]    sram_a1;
    logic [WIDTH-1:0] sram_i1;
    logic             sram_csb1, sram_web1, sram_oeb1;
    logic [AW-1:0]    sram_a2;
    logic             sram_csb2, sram_web2, sram_oeb2;
    logic [WIDTH-1:0] sram_o2;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int total = 0;
    int bad   = 0;
    int occ   = 0;

    sram2rw_fifo_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_bits  (enq_bits),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_bits  (deq_bits),
        .count     (count),
        .sram_a1   (sram_a1),
        .sram_i1   (sram_i1),
        .sram_csb1 (sram_csb1),
        .sram_web1 (sram_web1),
        .sram_oeb1 (sram_oeb1),
        .sram_a2   (sram_a2),
        .sram_csb2 (sram_csb2),
        .sram_web2 (sram_web2),
        .sram_oeb2 (sram_oeb2),
        .sram_o2   (sram_o2)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // Two-port SRAM with registered read data
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
        sram_o2 = '0;
    end

    always @(posedge clock) begin
        if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
        if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one call is one clock cycle; inputs change 1 time unit after the rising edge.
    task automatic drive(input logic ev, input logic [WIDTH-1:0] eb, input logic dr,
                         input logic rst, output logic fired);
        @(posedge clock);
        #1;
        reset     = rst;
        enq_valid = ev;
        enq_bits  = eb;
        deq_ready = dr;
        if (rst) exp_q.delete();
        #1;
        fired = enq_valid && enq_ready;
        if (fired) exp_q.push_back(enq_bits);
    endtask

    task automatic drain(input string name);
        logic f;
        for (int i = 0; i < 400; i++) begin
            if (count == '0) break;
            drive(1'b0, '0, 1'b1, 1'b0, f);
        end
        drive(1'b0, '0, 1'b0, 1'b0, f);
        check({name, "_count"}, 32'(count), 0);
        check({name, "_queue"}, exp_q.size(), 0);
    endtask

    // Scoreboard monitor: occupancy and data order, sampled on the falling edge.
    always @(negedge clock) begin
        logic [WIDTH-1:0] exp_v;
        if (reset) begin
            occ = 0;
        end else begin
            check("count_vs_model", 32'(count), occ);
            if (!sram_csb1 && !sram_csb2)
                check("port_addr_differ", 32'(sram_a1 != sram_a2), 1);
            if (enq_valid && enq_ready) occ++;
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    check("deq_unexpected", 32'(deq_bits), 32'hFFFF_FFFF);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("deq_data", 32'(deq_bits), 32'(exp_v));
                end
                occ--;
            end
        end
    end

    initial begin
        logic f;
        int lat, n_enq, n_deq, first, last;
        reset = 1'b1; enq_valid = 1'b0; enq_bits = '0; deq_ready = 1'b0;

        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, f);
        check("rst_enq_ready", 32'(enq_ready), 0);
        check("rst_deq_valid", 32'(deq_valid), 0);
        check("rst_count", 32'(count), 0);
        check("rst_deq_bits", 32'(deq_bits), 0);
        check("rst_csb1", 32'(sram_csb1), 1);
        check("rst_csb2", 32'(sram_csb2), 1);
        check("rst_web1", 32'(sram_web1), 1);
        check("rst_web2", 32'(sram_web2), 1);
        check("rst_oeb1", 32'(sram_oeb1), 1);
        check("rst_oeb2", 32'(sram_oeb2), 1);
        check("rst_a1", 32'(sram_a1), 0);
        check("rst_a2", 32'(sram_a2), 0);
        drive(1'b0, '0, 1'b0, 1'b0, f);
        check("idle_enq_ready", 32'(enq_ready), 1);

        // Single-word latency
        drive(1'b1, 8'hA5, 1'b1, 1'b0, f);
        check("lat_accept", 32'(f), 1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, f);
            if (deq_valid) begin
                lat = k;
                check("lat_data", 32'(deq_bits), 32'hA5);
                break;
            end
        end
        check("lat_cycles", lat, LAT);
        drive(1'b0, '0, 1'b1, 1'b0, f);
        check("lat_count_after", 32'(count), 0);

        // Fill to capacity with the consumer stalled
        for (int i = 0; i < 66; i++) begin
            f = 1'b0;
            for (int t = 0; t < 10 && !f; t++) drive(1'b1, 8'(i), 1'b0, 1'b0, f);
            check("fill_accept", 32'(f), 1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0, f);
        check("full_count", 32'(count), 66);
        check("full_enq_ready", 32'(enq_ready), 0);
        check("full_deq_valid", 32'(deq_valid), 1);
        check("full_head", 32'(deq_bits), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h77, 1'b0, 1'b0, f);
            check("ob_full_no_rd", 32'(sram_csb2), 1);
            check("full_no_accept", 32'(f), 0);
        end
        drive(1'b1, 8'h99, 1'b1, 1'b0, f);
        check("full_ready_ignores_deq", 32'(f), 0);
        drain("fill_drain");

        // Streaming across the pointer wrap
        n_enq = 0; n_deq = 0; first = -1; last = -1;
        for (int c = 0; c < 600 && n_deq < 200; c++) begin
            drive(n_enq < 200, 8'($urandom_range(0, 255)), 1'b1, 1'b0, f);
            if (f) n_enq++;
            if (deq_valid) begin
                if (first < 0) first = c;
                last = c;
                n_deq++;
            end
        end
        check("stream_enqs", n_enq, 200);
        check("stream_deqs", n_deq, 200);
        check("stream_no_bubble", last - first + 1, 200);
        drain("stream_drain");

        // Random traffic
        for (int c = 0; c < 10000; c++)
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1)), 1'b0, f);
        drain("random_drain");

        // Reset in the middle of traffic
        for (int i = 0; i < 30; i++) begin
            f = 1'b0;
            for (int t = 0; t < 10 && !f; t++) drive(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0, f);
            check("mid_fill_accept", 32'(f), 1);
        end
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, 1'b0, f);
        check("mid_count", 32'(count), 30);
        drive(1'b0, '0, 1'b1, 1'b0, f);
        check("mid_rd_issued", 32'(sram_csb2), 0);
        drive(1'b1, 8'h11, 1'b0, 1'b1, f);
        check("inrst_csb1", 32'(sram_csb1), 1);
        check("inrst_csb2", 32'(sram_csb2), 1);
        check("inrst_no_accept", 32'(f), 0);
        drive(1'b0, '0, 1'b0, 1'b0, f);
        check("postrst_count", 32'(count), 0);
        check("postrst_deq_valid", 32'(deq_valid), 0);
        check("postrst_csb1", 32'(sram_csb1), 1);
        check("postrst_csb2", 32'(sram_csb2), 1);
        drive(1'b1, 8'h3C, 1'b1, 1'b0, f);
        check("postrst_accept", 32'(f), 1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, '0, 1'b1, 1'b0, f);
            if (deq_valid) begin
                lat = k;
                check("postrst_first", 32'(deq_bits), 32'h3C);
                break;
            end
        end
        check("postrst_lat", lat, LAT);
        drain("final_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
